// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer engine: FSM state encoding,
// default fixed-point format and the signed saturation helper.
package ann_pkg;

  localparam int DW_DEF   = 10;
  localparam int FRAC_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  // The result is returned sign-extended to 64 bits; callers truncate.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ann_mac.sv
// Signed multiply-accumulate with synchronous clear. One instance is
// time-shared by every neuron of the layer.
module ann_mac #(
  parameter int DW = 10,
  parameter int AW = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  // Full-precision product; operands are sign-extended before multiplying.
  always_comb begin
    prod = (2*DW)'(a) * (2*DW)'(b);
  end

  // Accumulator: clear wins over accumulate.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/ann_layer_engine.sv
// One fully connected layer: weights are streamed in neuron-major order,
// then each start evaluates all neurons serially through one shared MAC.
// Optional feature: define ANN_RELU_EN to clamp negative results to zero.
//
// Weight handshake: a beat transfers on a rising Clock edge where both
// w_valid and w_ready are high; w_data must be stable while w_valid is high
// and w_ready may drop without the beat being consumed.
module ann_layer_engine
  import ann_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int N_IN  = 30,
  parameter int N_NEU = 5
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DW-1:0]         w_data,
  input  logic                  start,
  input  logic [N_IN*DW-1:0]    in_vec,
  output logic                  busy,
  output logic                  done,
  output logic [N_NEU*DW-1:0]   out_vec,
  output state_t                dbg_state
);

  localparam int N_W = N_IN * N_NEU;
  localparam int AW  = 2 * DW + $clog2(N_IN);
  localparam int WPW = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW  = (N_NEU > 1) ? $clog2(N_NEU) : 1;

  localparam logic [WPW-1:0] WP_LAST = WPW'(N_W - 1);
  localparam logic [IW-1:0]  I_LAST  = IW'(N_IN - 1);
  localparam logic [NW-1:0]  N_LAST  = NW'(N_NEU - 1);

  state_t                 state, state_nxt;
  logic [WPW-1:0]         wp;
  logic                   w_loaded;
  logic [IW-1:0]          i_cnt;
  logic [NW-1:0]          n_cnt;
  logic [N_IN*DW-1:0]     in_reg;
  logic signed [DW-1:0]   w_mem [N_W];
  logic                   done_q;
  logic                   beat;
  logic                   start_acc;
  logic                   mac_en;
  logic                   mac_clr;
  logic [WPW-1:0]         w_addr;
  logic signed [DW-1:0]   mac_a;
  logic signed [DW-1:0]   mac_b;
  logic signed [AW-1:0]   acc;
  logic signed [63:0]     acc64;
  logic signed [DW-1:0]   res_sat;
  logic signed [DW-1:0]   res;

  assign start_acc = (state == IDLE) && start && w_loaded;
  assign w_ready   = !Rst && ((state == IDLE) || (state == LOAD)) && !start_acc;
  assign beat      = w_valid && w_ready;
  assign busy      = (state == MAC) || (state == STORE);
  assign done      = done_q;
  assign dbg_state = state;

  assign w_addr = WPW'(int'(n_cnt) * N_IN + int'(i_cnt));
  assign mac_a  = signed'(in_reg[int'(i_cnt)*DW +: DW]);
  assign mac_b  = w_mem[w_addr];

  // Rescale the accumulator to the data format and saturate.
  assign acc64   = {{(64-AW){acc[AW-1]}}, acc};
  assign res_sat = DW'(sat_signed(acc64 >>> FRAC, DW));
`ifdef ANN_RELU_EN
  assign res = res_sat[DW-1] ? '0 : res_sat;
`else
  assign res = res_sat;
`endif

  ann_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk (Clock),
    .rst (Rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (mac_b),
    .acc (acc)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and MAC control decode.
  always_comb begin
    state_nxt = state;
    mac_en    = 1'b0;
    mac_clr   = start_acc;
    case (state)
      IDLE: begin
        if (start_acc)  state_nxt = MAC;
        else if (beat)  state_nxt = (wp == WP_LAST) ? IDLE : LOAD;
      end
      LOAD: begin
        if (beat && (wp == WP_LAST)) state_nxt = IDLE;
      end
      MAC: begin
        mac_en = 1'b1;
        if (i_cnt == I_LAST) state_nxt = STORE;
      end
      STORE: begin
        mac_clr   = 1'b1;
        state_nxt = (n_cnt == N_LAST) ? DONE : MAC;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight storage; deliberately not reset so weights survive Rst.
  always_ff @(posedge Clock) begin
    if (beat) w_mem[wp] <= w_data;
  end

  // Datapath control: load pointer, counters, input latch, results, done.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      wp       <= '0;
      w_loaded <= 1'b0;
      i_cnt    <= '0;
      n_cnt    <= '0;
      in_reg   <= '0;
      out_vec  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (beat) begin
        if (wp == WP_LAST) begin
          wp       <= '0;
          w_loaded <= 1'b1;
        end else begin
          wp       <= wp + 1'b1;
          w_loaded <= 1'b0;
        end
      end
      if (start_acc) begin
        in_reg <= in_vec;
        i_cnt  <= '0;
        n_cnt  <= '0;
      end
      if (state == MAC) begin
        i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
      end
      if (state == STORE) begin
        out_vec[int'(n_cnt)*DW +: DW] <= res;
        n_cnt <= (n_cnt == N_LAST) ? '0 : n_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ann_layer_engine.sv
// Directed bench for ann_layer_engine (DW=10, FRAC=4, N_IN=3, N_NEU=2).
// Honours ANN_RELU_EN when choosing expected values for negative results.
module tb_ann_layer_engine;
  import ann_pkg::*;

  localparam int DW    = 10;
  localparam int FRAC  = 4;
  localparam int N_IN  = 3;
  localparam int N_NEU = 2;
  localparam int OW    = N_NEU * DW;

  logic                 Clock;
  logic                 Rst;
  logic                 w_valid;
  logic                 w_ready;
  logic [DW-1:0]        w_data;
  logic                 start;
  logic [N_IN*DW-1:0]   in_vec;
  logic                 busy;
  logic                 done;
  logic [OW-1:0]        out_vec;
  state_t               dbg_state;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  ann_layer_engine #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_NEU(N_NEU)) dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .start     (start),
    .in_vec    (in_vec),
    .busy      (busy),
    .done      (done),
    .out_vec   (out_vec),
    .dbg_state (dbg_state)
  );

  // Clock and idle input values.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [N_IN*DW-1:0] pack3(input int a, input int b, input int c);
    logic [DW-1:0] ea, eb, ec;
    ea = DW'(a);
    eb = DW'(b);
    ec = DW'(c);
    return {ec, eb, ea};
  endfunction

  function automatic logic [OW-1:0] both(input int v);
    logic [DW-1:0] e;
    e = DW'(v);
    return {e, e};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Driver: stream N_IN*N_NEU identical weight beats.
  task automatic load_weights(input int w);
    for (int k = 0; k < N_IN*N_NEU; k++) begin
      w_valid = 1'b1;
      w_data  = DW'(w);
      tick();
    end
    w_valid = 1'b0;
  endtask

  // Driver: issue start, scramble in_vec afterwards, wait for done.
  // poke_cycle > 0 re-asserts start and w_valid in that cycle of the run.
  task automatic start_and_wait(input logic [N_IN*DW-1:0] vec, input int poke_cycle,
                                output int lat);
    start  = 1'b1;
    in_vec = vec;
    tick();
    start  = 1'b0;
    in_vec = N_IN*DW'($urandom_range(0, 32'h3FFF_FFFF));
    lat    = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == poke_cycle) begin
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = DW'(1);
        #1;
        checks++;
        if (w_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL mac_poke: w_ready=%b busy=%b required w_ready=0 busy=1", w_ready, busy);
        end
      end
      tick();
      start   = 1'b0;
      w_valid = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int lat);
    logic [OW-1:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles required 9", name, lat);
    end
    checks++;
    if (out_vec !== exp) begin
      errors++;
      $display("FAIL %s_out: got %h required %h", name, out_vec, exp);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b busy=%b required 0 0 one cycle after done", name, done, busy);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; w_valid = 1'b0; w_data = '0; start = 1'b0; in_vec = '0;
    tick();
    tick();
    checks++;
    if (w_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_vec !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset: w_ready=%b busy=%b done=%b out=%h state=%0d required 0 0 0 0 IDLE",
               w_ready, busy, done, out_vec, dbg_state);
    end
    Rst = 1'b0;
    tick();
    checks++;
    if (w_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", w_ready);
    end
  endtask

  task automatic test_start_no_weights();
    start  = 1'b1;
    in_vec = pack3(16, 32, 48);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE || w_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_unloaded: busy=%b done=%b state=%0d w_ready=%b required 0 0 IDLE 1",
                 busy, done, dbg_state, w_ready);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    load_weights(16);
    start  = 1'b1;
    in_vec = pack3(16, 32, 48);
    #1;
    checks++;
    if (w_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_on_start: got %b required 0", w_ready);
    end
    exp_q.push_back(both(96));
    start_and_wait(pack3(16, 32, 48), 0, lat);
    check_result("basic", lat);
  endtask

  task automatic test_saturation();
    int lat;
    load_weights(511);
    exp_q.push_back(both(511));
    start_and_wait(pack3(511, 511, 511), 0, lat);
    check_result("saturate", lat);
  endtask

  task automatic test_negative();
    int lat;
    load_weights(16);
`ifdef ANN_RELU_EN
    exp_q.push_back(both(0));
`else
    exp_q.push_back({10'h3D0, 10'h3D0});
`endif
    start_and_wait(pack3(-16, -16, -16), 0, lat);
    check_result("negative", lat);
  endtask

  task automatic test_start_during_load_mac();
    int lat;
    for (int k = 0; k < N_IN*N_NEU; k++) begin
      w_valid = 1'b1;
      w_data  = DW'(16);
      start   = (k == 2 || k == 3);
      tick();
      if (k == 2 || k == 3) begin
        checks++;
        if (dbg_state !== LOAD || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL start_in_load: state=%0d busy=%b done=%b required LOAD 0 0",
                   dbg_state, busy, done);
        end
      end
    end
    w_valid = 1'b0;
    start   = 1'b0;
    exp_q.push_back(both(96));
    start_and_wait(pack3(16, 32, 48), 2, lat);
    check_result("start_in_mac", lat);
  endtask

  task automatic test_reset_mid_mac();
    start  = 1'b1;
    in_vec = pack3(16, 32, 48);
    tick();
    start = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if (dbg_state !== IDLE || out_vec !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mac: state=%0d out=%h busy=%b required IDLE 0 0", dbg_state, out_vec, busy);
    end
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_cleared_loaded: done=%b busy=%b required 0 0", done, busy);
      end
    end
    start = 1'b0;
    load_weights(16);
    begin
      int lat;
      exp_q.push_back(both(96));
      start_and_wait(pack3(16, 32, 48), 0, lat);
      check_result("reload", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_q.push_back(both(16));
    start_and_wait(pack3(0, 0, 16), 0, lat);
    check_result("rerun", lat);
    for (int c = 0; c < 4; c++) begin
      in_vec = N_IN*DW'($urandom_range(0, 32'h3FFF_FFFF));
      tick();
    end
    checks++;
    if (out_vec !== both(16)) begin
      errors++;
      $display("FAIL hold_out: got %h required %h", out_vec, both(16));
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_start_no_weights();
    test_basic();
    test_saturation();
    test_negative();
    test_start_during_load_mac();
    test_reset_mid_mac();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ann_layer_engine.md
ANN_LAYER_ENGINE -- requirements
Module: ann_layer_engine

Interface
REQ-001 SHALL have parameter DW, default 10: data/weight width, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 4: fractional bits of the fixed-point format.
REQ-003 SHALL have parameter N_IN, default 30: inputs per neuron.
REQ-004 SHALL have parameter N_NEU, default 5: neurons in the layer.
REQ-005 SHALL have port Clock, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port w_valid, input, 1: weight beat valid.
REQ-008 SHALL have port w_ready, output, 1: weight beat accepted when high with w_valid.
REQ-009 SHALL have port w_data, input, DW: weight value.
REQ-010 SHALL have port start, input, 1: begin one layer evaluation.
REQ-011 SHALL have port in_vec, input, N_IN*DW: input vector, element i at bits [i*DW +: DW].
REQ-012 SHALL have port busy, output, 1: evaluation in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse, out_vec valid.
REQ-014 SHALL have port out_vec, output, N_NEU*DW: neuron results, neuron n at [n*DW +: DW].

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, MAC, STORE, DONE.
REQ-016 SHALL drive w_ready = (state is IDLE or LOAD) and not (state IDLE with start and w_loaded).
REQ-017 SHALL write accepted weights neuron-major at pointer wp (index n*N_IN+i), wp incrementing per beat; IDLE->LOAD on first beat.
REQ-018 SHALL, on the beat at wp = N_IN*N_NEU-1, wrap wp to 0, set w_loaded, and return to IDLE.
REQ-019 SHALL accept start only in IDLE with w_loaded=1; otherwise ignore it (no state change, no done).
REQ-020 SHALL register in_vec on the accepted start cycle; later in_vec changes have no effect.
REQ-021 SHALL in MAC perform one product in_vec[i]*w[n*N_IN+i] per cycle into accumulator width 2*DW+$clog2(N_IN).
REQ-022 SHALL after N_IN MAC cycles spend one STORE cycle: result = acc arithmetic-shifted right by FRAC, saturated to signed DW range, written to out_vec neuron n, acc cleared.
REQ-023 SHALL after STORE of neuron N_NEU-1 enter DONE, pulse done for exactly one cycle, then IDLE.
REQ-024 SHALL give latency: done high exactly N_NEU*(N_IN+1)+1 cycles after the start-accept edge.
REQ-025 SHALL hold busy high in MAC and STORE; low in IDLE, LOAD, DONE.
REQ-026 SHALL hold out_vec stable except during STORE writes; it retains the last result between evaluations.
REQ-027 SHALL keep weights for repeated evaluations without reload; a new load beat in IDLE restarts at wp=0 and clears w_loaded.

Reset
REQ-028 SHALL on Rst: state IDLE, wp 0, w_loaded 0, acc 0, out_vec 0, done 0, busy 0, w_ready 0 during reset; weight storage not cleared.
REQ-029 SHALL on Rst mid-LOAD or mid-MAC abandon the operation with no done pulse.

Configuration
REQ-030 SHALL with macro ANN_RELU_EN defined, replace negative STORE results by 0 after saturation; without it, results pass signed.

Structure
REQ-031 SHALL place the state enum, default DW/FRAC constants, and the saturation function in package ann_pkg.
REQ-032 SHALL instantiate one sub-module ann_mac (multiply-accumulate with clear), shared across all neurons.

Verification (DW=10, FRAC=4, N_IN=3, N_NEU=2)
REQ-033 SHALL check: load 6 weights of 16, start with in_vec {16,32,48} -> done at cycle 9, out_vec both 96.
REQ-034 SHALL check: all weights 511, inputs 511 -> both outputs saturate to 511.
REQ-035 SHALL check: weights 16, inputs -16 -> outputs 10'h3D0 (-48); with ANN_RELU_EN -> 0.
REQ-036 SHALL check: start after reset with no weights, or during LOAD/MAC -> ignored, no done, busy unchanged.
REQ-037 SHALL check: Rst at MAC cycle 3 -> IDLE, out_vec 0, w_loaded 0, no done; reload and rerun gives 96.
REQ-038 SHALL check: second start without reload, in_vec {0,0,16} -> out_vec both 16; w_valid in MAC sees w_ready 0.
